me_req_sequencer: RTL and testbench

//   Frame-level sequencer directly downstream of the motion-estimation control block.

---
 rtl/me_req_sequencer.sv | 145 ++++++++++++++
 tb/tb_me_req_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/me_req_sequencer.sv
// Frame sequencer for the motion-estimation block: one req/ack search per macroblock,
// signed motion-vector conversion, and a show-ahead result FIFO read over valid/ready.
module me_req_sequencer #(
  parameter int MB_COUNT   = 16,
  parameter int SW_LENGTH  = 32,
  parameter int TB_LENGTH  = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int MB_W      = $clog2(MB_COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  output logic [MB_W-1:0]  mb_index,
  output logic             me_req,
  input  logic             me_ack,
  input  logic [15:0]      me_min_sad,
  input  logic [9:0]       me_min_mvec,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [MB_W+27:0] res_data
);

  localparam int MV_OFFSET = (TB_LENGTH - 1) + (SW_LENGTH - TB_LENGTH) / 2;
  localparam logic [5:0] MV_OFF6 = 6'(MV_OFFSET);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = MB_W + 28;
  localparam logic [MB_W-1:0] LAST_MB = MB_W'(MB_COUNT - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DROP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [MB_W-1:0] r_mb_index;
  logic            r_frame_done;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_mb_clr;
  logic            w_mb_inc;
  logic            w_done;
  logic [5:0]      w_mvx;
  logic [5:0]      w_mvy;
  logic [EW-1:0]   w_entry;

  logic [EW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;

  assign w_mvx   = {1'b0, me_min_mvec[4:0]} - MV_OFF6;
  assign w_mvy   = {1'b0, me_min_mvec[9:5]} - MV_OFF6;
  assign w_entry = {r_mb_index, me_min_sad, w_mvy, w_mvx};

  // Full is taken from the registered count, so a same-cycle pop cannot free a slot for this push.
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = res_valid && res_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_mb_clr    = 1'b0;
    w_mb_inc    = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // frame_done is only ever high in the first IDLE cycle; a start there is dropped.
        if (start && !r_frame_done) begin
          w_state_nxt = ST_REQ;
          w_mb_clr    = 1'b1;
        end
      end
      ST_REQ: begin
        if (me_ack && !w_full) begin
          w_push      = 1'b1;
          w_state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (!me_ack) begin
          if (r_mb_index == LAST_MB) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_mb_inc    = 1'b1;
            w_state_nxt = ST_REQ;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_mb_index   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_done;
      if (w_mb_clr) begin
        r_mb_index <= '0;
      end else if (w_mb_inc) begin
        r_mb_index <= r_mb_index + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign me_req     = (r_state == ST_REQ);
  assign frame_done = r_frame_done;
  assign mb_index   = r_mb_index;
  assign res_valid  = (r_count != '0);
  assign res_data   = r_mem[r_rptr];

endmodule

// File: tb/tb_me_req_sequencer.sv
// Scoreboard bench for me_req_sequencer: an ME-control responder queues the expected
// result word when it raises ack; a monitor pops and compares on each host handshake.
module tb_me_req_sequencer;

  localparam int MBC = 6;
  localparam int MBW = $clog2(MBC);
  localparam int DW  = MBW + 28;
  localparam int RY[6] = '{19, 7, 31, 12, 20, 7};
  localparam int RX[6] = '{19, 31, 7, 25, 18, 7};

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           busy;
  logic           frame_done;
  logic [MBW-1:0] mb_index;
  logic           me_req;
  logic           me_ack;
  logic [15:0]    me_min_sad;
  logic [9:0]     me_min_mvec;
  logic           res_valid;
  logic           res_ready;
  logic [DW-1:0]  res_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  int exp_mb   = 0;
  int blk_seq  = 0;
  int ack_lat  = 20;
  int rel_hold = 0;
  int n_pops   = 0;
  bit resp_en  = 1'b0;

  always #5 clk = ~clk;

  me_req_sequencer #(.MB_COUNT(MBC), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .mb_index(mb_index), .me_req(me_req), .me_ack(me_ack), .me_min_sad(me_min_sad),
    .me_min_mvec(me_min_mvec), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    @(negedge clk);
    while (!frame_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(tag, frame_done, 1);
  endtask

  // ME control block model
  initial begin : responder
    int ry, rx, t, mbv;
    me_ack = 1'b0; me_min_sad = '0; me_min_mvec = '0;
    forever begin
      @(negedge clk);
      if (resp_en && rst_n && me_req && !me_ack) begin
        repeat (ack_lat) @(posedge clk);
        #1;
        if (rst_n) begin
          ry = RY[blk_seq % 6];
          rx = RX[blk_seq % 6];
          me_min_sad  = 16'h0123 + 16'(blk_seq);
          me_min_mvec = {5'(ry), 5'(rx)};
          me_ack = 1'b1;
          check("ack_mb_index", mb_index, exp_mb);
          exp_q.push_back({MBW'(exp_mb), me_min_sad, 6'(ry - 19), 6'(rx - 19)});
          exp_mb = (exp_mb == MBC - 1) ? 0 : exp_mb + 1;
          blk_seq++;
          mbv = mb_index;
          t = 0;
          while (me_req && t < 1000) begin
            @(negedge clk);
            t++;
          end
          if (t >= 1000) check("req_fall_timeout", me_req, 0);
          for (int i = 0; i < rel_hold; i++) begin
            @(negedge clk);
            check("req_low_while_ack", me_req, 0);
            check("mb_hold_while_ack", mb_index, mbv);
          end
          @(posedge clk); #1 me_ack = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    logic [DW-1:0] e;
    int fd_run;
    fd_run = 0;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        check("pop_expected_exists", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("res_data", res_data, e);
        end
        n_pops++;
      end
      if (frame_done) fd_run++;
      else if (fd_run != 0) begin
        check("frame_done_width", fd_run, 1);
        fd_run = 0;
      end
    end
  end

  initial begin : main
    int t, p0;
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_me_req", me_req, 0);
    check("rst_mb_index", mb_index, 0);
    check("rst_res_valid", res_valid, 0);
    rst_n = 1'b1;

    // Reset mid-frame while searching block 2
    res_ready = 1'b1; ack_lat = 20; resp_en = 1'b1;
    pulse_start();
    t = 0;
    @(negedge clk);
    while (!(me_req && mb_index == 2) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("reach_mb2", mb_index, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_me_req", me_req, 0);
    check("arst_busy", busy, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_mb_index", mb_index, 0);
    repeat (25) @(posedge clk);
    exp_q.delete();
    exp_mb = 0;
    #1 rst_n = 1'b1;

    // Full frame, host always ready
    p0 = n_pops;
    pulse_start();
    wait_done("frame1_done");
    @(negedge clk);
    check("frame1_done_low", frame_done, 0);
    check("frame1_idle", busy, 0);
    repeat (3) @(negedge clk);
    check("frame1_pops", n_pops - p0, MBC);
    check("frame1_q_empty", exp_q.size(), 0);

    // Back-pressure, then full FIFO with a pop in the same cycle as the waiting ack
    res_ready = 1'b0; ack_lat = 3;
    p0 = n_pops;
    pulse_start();
    t = 0;
    while (exp_q.size() < 5 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    check("bp_me_req", me_req, 1);
    check("bp_me_ack", me_ack, 1);
    check("bp_mb_index", mb_index, 4);
    check("bp_res_valid", res_valid, 1);
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("full_pop_req_held", me_req, 1);
    @(negedge clk);
    check("full_pop_pushed", me_req, 0);
    wait_done("frame2_done");
    repeat (6) @(negedge clk);
    check("frame2_pops", n_pops - p0, MBC);
    check("frame2_q_empty", exp_q.size(), 0);

    // Slow ack release
    ack_lat = 2; rel_hold = 10;
    pulse_start();
    wait_done("frame3_done");
    rel_hold = 0;
    repeat (4) @(negedge clk);

    // Start while busy and in the frame_done cycle
    ack_lat = 4;
    p0 = n_pops;
    pulse_start();
    repeat (10) @(posedge clk);
    #1 check("busy_before_start", busy, 1);
    pulse_start();
    repeat (17) @(posedge clk);
    pulse_start();
    wait_done("frame4_done");
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("start_on_done_busy", busy, 0);
    check("start_on_done_req", me_req, 0);
    repeat (5) @(negedge clk);
    check("still_idle", busy, 0);
    pulse_start();
    wait_done("frame5_done");
    repeat (4) @(negedge clk);
    check("frames45_pops", n_pops - p0, 2 * MBC);
    check("final_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
